// File: rtl/keypad_scan_decode.sv
// rtl/keypad_scan_decode.sv - 4x4 keypad scanner with debounce and calculator key decode
module keypad_scan_decode #(
  parameter int SCAN_DIV         = 48000,
  parameter int DEBOUNCE_SAMPLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       is_number,
  output logic       is_operation,
  output logic [1:0] op_code,
  output logic       is_equals,
  output logic       is_clear,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SAMPLES);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    rows_m;
  logic [3:0]    rows_s;
  logic [DW-1:0] div;
  logic          tick;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [1:0]    low_row;
  logic [3:0]    pattern;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] rel;
  logic [CW-1:0] rel_inc;
  logic          lock;
  logic          accept;
  logic          advance;
  logic          release_done;
  logic [1:0]    acc_row;
  logic [3:0]    acc_code;

  // Row/column position to calculator key code
  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'd0;
    case ({r, c})
      4'h0: k = 4'd1;
      4'h1: k = 4'd2;
      4'h2: k = 4'd3;
      4'h3: k = 4'd10;
      4'h4: k = 4'd4;
      4'h5: k = 4'd5;
      4'h6: k = 4'd6;
      4'h7: k = 4'd11;
      4'h8: k = 4'd7;
      4'h9: k = 4'd8;
      4'hA: k = 4'd9;
      4'hB: k = 4'd12;
      4'hC: k = 4'd14;
      4'hD: k = 4'd0;
      4'hE: k = 4'd15;
      4'hF: k = 4'd13;
      default: k = 4'd0;
    endcase
    return k;
  endfunction

  assign tick    = (div == DIV_LAST);
  assign cols    = ~(4'b0001 << col_idx);
  assign cnt_inc = cnt + CW'(1);
  assign rel_inc = rel + CW'(1);

  // Lowest-index low row wins; the code is decoded from the live rows when
  // a single-sample debounce accepts straight out of SCAN
  always_comb begin
    low_row = 2'd3;
    if (!rows_s[0])      low_row = 2'd0;
    else if (!rows_s[1]) low_row = 2'd1;
    else if (!rows_s[2]) low_row = 2'd2;
    acc_row  = (state == SCAN) ? low_row : row_idx;
    acc_code = keymap(acc_row, col_idx);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= SCAN;
    else     state <= state_next;
  end

  // Next-state and control strobes, all decisions taken on scan ticks
  always_comb begin
    state_next   = state;
    lock         = 1'b0;
    accept       = 1'b0;
    advance      = 1'b0;
    release_done = 1'b0;
    case (state)
      SCAN: begin
        if (tick) begin
          if (rows_s == 4'hF) begin
            advance = 1'b1;
          end else begin
            lock = 1'b1;
            if (DEBOUNCE_SAMPLES == 1) begin
              accept     = 1'b1;
              state_next = HELD;
            end else begin
              state_next = DEBOUNCE;
            end
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (rows_s == pattern) begin
            if (cnt_inc == CNT_LAST) begin
              accept     = 1'b1;
              state_next = HELD;
            end
          end else begin
            advance    = 1'b1;
            state_next = SCAN;
          end
        end
      end
      HELD: begin
        if (tick && rows_s == 4'hF && rel_inc == CNT_LAST) begin
          release_done = 1'b1;
          advance      = 1'b1;
          state_next   = SCAN;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  // Synchroniser, scan divider, column pointer, counters and decoded outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_m       <= 4'hF;
      rows_s       <= 4'hF;
      div          <= '0;
      col_idx      <= 2'd0;
      row_idx      <= 2'd0;
      pattern      <= 4'hF;
      cnt          <= '0;
      rel          <= '0;
      key_valid    <= 1'b0;
      key_code     <= 4'd0;
      is_number    <= 1'b0;
      is_operation <= 1'b0;
      op_code      <= 2'd0;
      is_equals    <= 1'b0;
      is_clear     <= 1'b0;
      key_held     <= 1'b0;
    end else begin
      rows_m    <= rows;
      rows_s    <= rows_m;
      div       <= tick ? '0 : div + DW'(1);
      key_valid <= accept;
      if (advance) col_idx <= col_idx + 2'd1;
      if (lock) begin
        row_idx <= low_row;
        pattern <= rows_s;
        cnt     <= CW'(1);
      end else if (state == DEBOUNCE && tick && rows_s == pattern) begin
        cnt <= cnt_inc;
      end
      if (state == HELD && tick) rel <= (rows_s == 4'hF) ? rel_inc : '0;
      if (accept) begin
        key_code     <= acc_code;
        is_number    <= (acc_code <= 4'd9);
        is_operation <= (acc_code >= 4'd10) && (acc_code <= 4'd13);
        op_code      <= ((acc_code >= 4'd10) && (acc_code <= 4'd13)) ? 2'(acc_code - 4'd10) : 2'd0;
        is_equals    <= (acc_code == 4'd15);
        is_clear     <= (acc_code == 4'd14);
        key_held     <= 1'b1;
        rel          <= '0;
      end
      if (release_done) begin
        key_held <= 1'b0;
        rel      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_decode.sv
// tb/tb_keypad_scan_decode.sv - directed bench for keypad_scan_decode
module tb_keypad_scan_decode;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       key_valid;
  logic [3:0] key_code;
  logic       is_number;
  logic       is_operation;
  logic [1:0] op_code;
  logic       is_equals;
  logic       is_clear;
  logic       key_held;

  logic [3:0][3:0] pressed;   // pressed[row][col]
  int checks = 0;
  int fails = 0;
  int pulse_cnt = 0;
  logic [3:0] last_code = 4'd0;
  logic [3:0] last_flags = 4'd0;  // {is_number, is_operation, is_equals, is_clear}
  logic [1:0] last_opc = 2'd0;

  keypad_scan_decode #(.SCAN_DIV(4), .DEBOUNCE_SAMPLES(3)) dut (
    .clk(clk), .rst(rst), .rows(rows), .cols(cols), .key_valid(key_valid),
    .key_code(key_code), .is_number(is_number), .is_operation(is_operation),
    .op_code(op_code), .is_equals(is_equals), .is_clear(is_clear), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !cols[c]) rows[r] = 1'b0;
  end

  // Pulse counter and capture of the decoded event
  always @(posedge clk) begin
    if (key_valid) begin
      pulse_cnt  <= pulse_cnt + 1;
      last_code  <= key_code;
      last_flags <= {is_number, is_operation, is_equals, is_clear};
      last_opc   <= op_code;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst = 1'b1;
    pressed = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pulse(input int base, input int limit, output int n);
    n = 0;
    while (pulse_cnt == base && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_unheld(input int limit, output int n);
    n = 0;
    while (key_held && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_cols(input logic [3:0] c, input int limit, output int n);
    n = 0;
    while (cols !== c && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    pressed = '0;
    repeat (3) @(negedge clk);
    checks++; if (cols !== 4'b1110) begin fails++; $display("FAIL reset_cols: got %b expected 1110", cols); end
    checks++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin fails++; $display("FAIL reset_held: got %b expected 0", key_held); end
    checks++; if (key_code !== 4'd0) begin fails++; $display("FAIL reset_code: got %0d expected 0", key_code); end
    checks++; if ({is_number, is_operation, op_code, is_equals, is_clear} !== 6'd0) begin
      fails++; $display("FAIL reset_flags: got %b expected 000000", {is_number, is_operation, op_code, is_equals, is_clear});
    end
    rst = 1'b0;
    wait_cols(4'b1101, 20, n);
    checks++; if (n !== 4) begin fails++; $display("FAIL scan_first_tick: got %0d cycles expected 4", n); end
    wait_cols(4'b1011, 20, n);
    checks++; if (n !== 4) begin fails++; $display("FAIL scan_period: got %0d cycles expected 4", n); end
  endtask

  task automatic test_press_five();
    int base, n;
    do_reset();
    base = pulse_cnt;
    pressed[1][1] = 1'b1;
    wait_pulse(base, 60, n);
    checks++; if (pulse_cnt !== base + 1) begin fails++; $display("FAIL five_pulse: got %0d pulses expected 1", pulse_cnt - base); end
    checks++; if (n !== 17) begin fails++; $display("FAIL five_latency: got %0d cycles expected 17", n); end
    checks++; if (last_code !== 4'd5) begin fails++; $display("FAIL five_code: got %0d expected 5", last_code); end
    checks++; if (last_flags !== 4'b1000) begin fails++; $display("FAIL five_flags: got %b expected 1000", last_flags); end
    repeat (140) @(negedge clk);
    checks++; if (pulse_cnt !== base + 1) begin fails++; $display("FAIL five_hold_pulses: got %0d expected 1", pulse_cnt - base); end
    checks++; if (key_held !== 1'b1) begin fails++; $display("FAIL five_held: got %b expected 1", key_held); end
    pressed = '0;
    wait_unheld(40, n);
    checks++; if (n < 11 || n > 14) begin fails++; $display("FAIL five_release_time: got %0d cycles expected 11..14", n); end
    checks++; if (cols !== 4'b1011) begin fails++; $display("FAIL five_resume_col: got %b expected 1011", cols); end
    repeat (40) @(negedge clk);
    checks++; if (pulse_cnt !== base + 1) begin fails++; $display("FAIL five_after_release: got %0d pulses expected 1", pulse_cnt - base); end
  endtask

  task automatic test_bounce();
    int base, n;
    do_reset();
    base = pulse_cnt;
    wait_cols(4'b0111, 40, n);
    checks++; if (cols !== 4'b0111) begin fails++; $display("FAIL bounce_reach_col3: got %b expected 0111", cols); end
    pressed[0][3] = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (cols !== 4'b0111) begin fails++; $display("FAIL bounce_locked: got %b expected 0111", cols); end
    pressed = '0;
    repeat (4) @(negedge clk);
    checks++; if (cols !== 4'b1110) begin fails++; $display("FAIL bounce_unlock: got %b expected 1110", cols); end
    repeat (4) @(negedge clk);
    checks++; if (cols !== 4'b1101) begin fails++; $display("FAIL bounce_rotating: got %b expected 1101", cols); end
    repeat (16) @(negedge clk);
    checks++; if (pulse_cnt !== base || key_held !== 1'b0) begin
      fails++; $display("FAIL bounce_no_event: got %0d pulses held=%b expected 0 pulses held=0", pulse_cnt - base, key_held);
    end
  endtask

  task automatic test_ops();
    int base, n;
    logic [1:0] kr [3] = '{2'd0, 2'd3, 2'd3};
    logic [1:0] kc [3] = '{2'd3, 2'd2, 2'd0};
    logic [3:0] ec [3] = '{4'd10, 4'd15, 4'd14};
    logic [3:0] ef [3] = '{4'b0100, 4'b0010, 4'b0001};
    for (int i = 0; i < 3; i++) begin
      base = pulse_cnt;
      pressed[kr[i]][kc[i]] = 1'b1;
      wait_pulse(base, 40, n);
      checks++; if (pulse_cnt !== base + 1) begin fails++; $display("FAIL ops_pulse[%0d]: got %0d expected 1", i, pulse_cnt - base); end
      checks++; if (last_code !== ec[i]) begin fails++; $display("FAIL ops_code[%0d]: got %0d expected %0d", i, last_code, ec[i]); end
      checks++; if (last_flags !== ef[i]) begin fails++; $display("FAIL ops_flags[%0d]: got %b expected %b", i, last_flags, ef[i]); end
      checks++; if (last_opc !== 2'd0) begin fails++; $display("FAIL ops_opcode[%0d]: got %0d expected 0", i, last_opc); end
      pressed = '0;
      wait_unheld(40, n);
      checks++; if (key_held !== 1'b0) begin fails++; $display("FAIL ops_release[%0d]: got %b expected 0", i, key_held); end
    end
  endtask

  task automatic test_multi();
    int base, n;
    base = pulse_cnt;
    pressed[1][0] = 1'b1;
    pressed[2][0] = 1'b1;
    wait_pulse(base, 40, n);
    checks++; if (last_code !== 4'd4) begin fails++; $display("FAIL multi_code: got %0d expected 4", last_code); end
    pressed[0][2] = 1'b1;
    repeat (80) @(negedge clk);
    checks++; if (pulse_cnt !== base + 1) begin fails++; $display("FAIL multi_pulses: got %0d expected 1", pulse_cnt - base); end
    checks++; if (key_code !== 4'd4 || key_held !== 1'b1) begin
      fails++; $display("FAIL multi_hold: got code %0d held %b expected code 4 held 1", key_code, key_held);
    end
    pressed = '0;
    wait_unheld(40, n);
    checks++; if (key_held !== 1'b0) begin fails++; $display("FAIL multi_release: got %b expected 0", key_held); end
  endtask

  task automatic test_reset_held();
    int base, n;
    base = pulse_cnt;
    pressed[1][1] = 1'b1;
    wait_pulse(base, 40, n);
    checks++; if (pulse_cnt !== base + 1) begin fails++; $display("FAIL rh_first_pulse: got %0d expected 1", pulse_cnt - base); end
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cols !== 4'b1110 || key_held !== 1'b0 || key_valid !== 1'b0) begin
      fails++; $display("FAIL rh_reset_state: got cols %b held %b valid %b expected 1110 0 0", cols, key_held, key_valid);
    end
    rst = 1'b0;
    base = pulse_cnt;
    wait_pulse(base, 40, n);
    checks++; if (pulse_cnt !== base + 1 || last_code !== 4'd5) begin
      fails++; $display("FAIL rh_redetect: got %0d pulses code %0d expected 1 pulse code 5", pulse_cnt - base, last_code);
    end
    repeat (60) @(negedge clk);
    checks++; if (pulse_cnt !== base + 1) begin fails++; $display("FAIL rh_single: got %0d pulses expected 1", pulse_cnt - base); end
    pressed = '0;
    wait_unheld(40, n);
  endtask

  task automatic test_double_nine();
    int base, n;
    logic dropped;
    base = pulse_cnt;
    dropped = 1'b0;
    pressed[2][2] = 1'b1;
    wait_pulse(base, 40, n);
    checks++; if (last_code !== 4'd9) begin fails++; $display("FAIL nine_code: got %0d expected 9", last_code); end
    repeat (8) @(negedge clk);
    pressed = '0;
    repeat (8) begin @(negedge clk); if (!key_held) dropped = 1'b1; end
    pressed[2][2] = 1'b1;
    repeat (40) begin @(negedge clk); if (!key_held) dropped = 1'b1; end
    checks++; if (dropped !== 1'b0) begin fails++; $display("FAIL nine_held_gap: got dropped=%b expected 0", dropped); end
    checks++; if (pulse_cnt !== base + 1) begin fails++; $display("FAIL nine_pulses: got %0d expected 1", pulse_cnt - base); end
    pressed = '0;
    wait_unheld(40, n);
    checks++; if (key_held !== 1'b0) begin fails++; $display("FAIL nine_release: got %b expected 0", key_held); end
  endtask

  initial begin
    rst = 1'b1;
    pressed = '0;
    test_reset();
    test_press_five();
    test_bounce();
    test_ops();
    test_multi();
    test_reset_held();
    test_double_nine();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
